xup_piso_serializer: RTL

- Parallel-in, serial-out converter for the XUP library: accepts a SIZE-bit vector through a valid/ready handshake and shifts it out one bit per enabled clock.
- Serves as the transmit end for vector-datapath blocks (gate-vector outputs, register banks) feeding single-wire links or LEDs in lab designs.
- Sequential counterpart to the combinational vector primitives. Same SIZE/DELAY parameter style.

---
 rtl/xup_piso_serializer_pkg.sv | 26 ++
 rtl/xup_bit_counter.sv | 41 ++++
 rtl/xup_piso_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/xup_piso_serializer_pkg.sv
// Shared definitions for XUP sequential blocks: FSM state encoding and a
// constant ceiling-log2 helper used to size counters.
package xup_piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2, clamped to at least 1 so a counter always has one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if (rem != 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/xup_bit_counter.sv
// Frame bit counter: counts enabled ticks from 0 to SIZE-1 and flags the last
// position. Shared with the companion deserializer.
module xup_bit_counter
  import xup_piso_serializer_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  localparam int unsigned CNT_W = clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority so a frame boundary never lets the count run past SIZE-1.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(SIZE - 1));

endmodule

// File: rtl/xup_piso_serializer.sv
// Parallel-in serial-out converter: accepts a SIZE-bit word over valid/ready
// and shifts it out one bit per ce-qualified clock, with gapless reload.
module xup_piso_serializer
  import xup_piso_serializer_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter int          DELAY     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SIZE-1:0] din,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            ce,
  output logic            sout,
  output logic            sout_valid,
  output logic            frame_start,
  output logic            frame_end,
  output logic            busy
);

  localparam int unsigned CNT_W = clog2(SIZE);

  // DELAY only shapes simulation timing elsewhere; here it is just range-checked.
  if (SIZE < 2 || SIZE > 32) begin : g_bad_size
    $error("xup_piso_serializer: SIZE must be in 2..32");
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("xup_piso_serializer: DELAY must be non-negative");
  end

  state_e            state_q;
  state_e            state_d;
  logic [SIZE-1:0]   shreg_q;
  logic [SIZE-1:0]   shreg_d;
  logic [CNT_W-1:0]  count;
  logic              last;
  logic              accept;
  logic              bit_tick;
  logic              frame_done;

  assign bit_tick   = (state_q == ST_SHIFT) && ce;
  assign frame_done = bit_tick && last;
  assign accept     = load_valid && load_ready;

  xup_bit_counter #(
    .SIZE (SIZE)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept || frame_done),
    .en      (bit_tick),
    .count   (count),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A reload on the last bit keeps the FSM in SHIFT for a gapless next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (frame_done && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ready is withheld during reset so nothing is handed over while held.
  always_comb begin
    load_ready  = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = reset_n;
      end
      ST_SHIFT: begin
        sout_valid  = 1'b1;
        sout        = MSB_FIRST ? shreg_q[SIZE-1] : shreg_q[0];
        frame_start = (count == '0);
        frame_end   = last;
        load_ready  = reset_n && last && ce;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  assign busy = sout_valid;

  // Shift toward the output end with zero fill; a load overrides the shift.
  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = din;
    end else if (bit_tick) begin
      shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule
